// File: rtl/sine_addr_gen_if.sv
// Bus between the sine address generator and whoever controls it:
// run/sync controls, the frequency/offset update handshake, and the
// two ROM addresses plus the wrap pulse.
interface sine_addr_gen_if #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int FRAC_WIDTH    = 4
);
  logic                                en;
  logic                                sync;
  logic                                upd_req;
  logic [ADDRESS_WIDTH+FRAC_WIDTH-1:0] incr_in;
  logic [ADDRESS_WIDTH-1:0]            offset_in;
  logic                                upd_busy;
  logic                                upd_ack;
  logic [ADDRESS_WIDTH-1:0]            addr1;
  logic [ADDRESS_WIDTH-1:0]            addr2;
  logic                                wrap;

  // Controller side: drives the controls and update request.
  modport master (
    output en, sync, upd_req, incr_in, offset_in,
    input  upd_busy, upd_ack, addr1, addr2, wrap
  );

  // Generator side: consumes controls, produces addresses and status.
  modport slave (
    input  en, sync, upd_req, incr_in, offset_in,
    output upd_busy, upd_ack, addr1, addr2, wrap
  );
endinterface

// File: rtl/sine_addr_gen.sv
// Dual-phase ROM address generator. A fractional phase accumulator
// produces addr1; addr2 is addr1 plus a programmable offset. Frequency
// and offset updates are held in shadow registers and only take effect
// at a wrap boundary (or immediately when the generator is stopped or
// being re-synchronised), so the output waveform never glitches.
module sine_addr_gen #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int FRAC_WIDTH    = 4
) (
  input  logic clk,
  input  logic rst,
  sine_addr_gen_if.slave bus
);

  localparam int ACC_WIDTH = ADDRESS_WIDTH + FRAC_WIDTH;

  typedef enum logic {IDLE, PENDING} state_t;

  state_t                 state_q, state_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [ACC_WIDTH-1:0]   incr_act_q, incr_act_d;
  logic [ACC_WIDTH-1:0]   incr_sh_q, incr_sh_d;
  logic [ADDRESS_WIDTH-1:0] off_act_q, off_act_d;
  logic [ADDRESS_WIDTH-1:0] off_sh_q, off_sh_d;
  logic [ADDRESS_WIDTH-1:0] addr2_q, addr2_d;
  logic                   wrap_q, wrap_d;
  logic                   ack_q, ack_d;

  logic [ACC_WIDTH:0]     sum;
  logic                   carry;

  assign sum   = {1'b0, acc_q} + {1'b0, incr_act_q};
  assign carry = sum[ACC_WIDTH];

  // Next-state logic: accumulation, update handshake and phase sync.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    incr_act_d = incr_act_q;
    incr_sh_d  = incr_sh_q;
    off_act_d  = off_act_q;
    off_sh_d   = off_sh_q;
    wrap_d     = 1'b0;
    ack_d      = 1'b0;

    if (bus.sync) begin
      acc_d = '0;
      if (state_q == PENDING) begin
        incr_act_d = incr_sh_q;
        off_act_d  = off_sh_q;
        ack_d      = 1'b1;
        state_d    = IDLE;
      end else if (bus.upd_req) begin
        incr_act_d = bus.incr_in;
        off_act_d  = bus.offset_in;
        ack_d      = 1'b1;
      end
    end else begin
      if (bus.en) begin
        acc_d  = sum[ACC_WIDTH-1:0];
        wrap_d = carry;
      end
      if (state_q == IDLE) begin
        if (bus.upd_req) begin
          incr_sh_d = bus.incr_in;
          off_sh_d  = bus.offset_in;
          state_d   = PENDING;
        end
      end else if (!bus.en || carry) begin
        incr_act_d = incr_sh_q;
        off_act_d  = off_sh_q;
        ack_d      = 1'b1;
        state_d    = IDLE;
      end
    end

    addr2_d = acc_d[ACC_WIDTH-1:FRAC_WIDTH] + off_act_d;
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      incr_act_q <= ACC_WIDTH'(1) << FRAC_WIDTH;
      incr_sh_q  <= '0;
      off_act_q  <= '0;
      off_sh_q   <= '0;
      addr2_q    <= '0;
      wrap_q     <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      incr_act_q <= incr_act_d;
      incr_sh_q  <= incr_sh_d;
      off_act_q  <= off_act_d;
      off_sh_q   <= off_sh_d;
      addr2_q    <= addr2_d;
      wrap_q     <= wrap_d;
      ack_q      <= ack_d;
    end
  end

  assign bus.addr1    = acc_q[ACC_WIDTH-1:FRAC_WIDTH];
  assign bus.addr2    = addr2_q;
  assign bus.wrap     = wrap_q;
  assign bus.upd_ack  = ack_q;
  assign bus.upd_busy = (state_q == PENDING);

endmodule

// File: tb/tb_sine_addr_gen.sv
// Directed testbench for sine_addr_gen: a long free-run after reset,
// then a table of hand-computed vectors covering wrap-boundary updates,
// stopped-generator updates, sync, zero increment and offset wrap, plus
// an asynchronous reset in the middle of a pending update.
module tb_sine_addr_gen;

  typedef struct {
    int         cycles;
    logic       en;
    logic       sync;
    logic       req;
    logic [11:0] incr;
    logic [7:0] off;
    logic [7:0] a1;
    logic [7:0] a2;
    logic       wrap;
    logic       ack;
    logic       busy;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   failures = 0;
  vec_t vecs[$];

  sine_addr_gen_if #(.ADDRESS_WIDTH(8), .FRAC_WIDTH(4)) bus ();

  sine_addr_gen #(.ADDRESS_WIDTH(8), .FRAC_WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  function automatic vec_t mk(int cyc, int en, int sy, int rq, int inc, int off,
                              int a1, int a2, int w, int k, int b);
    vec_t v;
    v.cycles = cyc;
    v.en     = en[0];
    v.sync   = sy[0];
    v.req    = rq[0];
    v.incr   = inc[11:0];
    v.off    = off[7:0];
    v.a1     = a1[7:0];
    v.a2     = a2[7:0];
    v.wrap   = w[0];
    v.ack    = k[0];
    v.busy   = b[0];
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic checkAll(string tag, int a1, int a2, int w, int k, int b);
    checkOutput($sformatf("%s addr1", tag), int'(bus.addr1), a1);
    checkOutput($sformatf("%s addr2", tag), int'(bus.addr2), a2);
    checkOutput($sformatf("%s wrap", tag), int'(bus.wrap), w);
    checkOutput($sformatf("%s upd_ack", tag), int'(bus.upd_ack), k);
    checkOutput($sformatf("%s upd_busy", tag), int'(bus.upd_busy), b);
  endtask

  task automatic applyStimulus(vec_t v, int idx);
    bus.en        = v.en;
    bus.sync      = v.sync;
    bus.upd_req   = v.req;
    bus.incr_in   = v.incr;
    bus.offset_in = v.off;
    repeat (v.cycles) step();
    bus.upd_req = 1'b0;
    bus.sync    = 1'b0;
    checkAll($sformatf("vec%0d", idx), int'(v.a1), int'(v.a2), int'(v.wrap),
             int'(v.ack), int'(v.busy));
  endtask

  initial begin
    bus.en        = 1'b0;
    bus.sync      = 1'b0;
    bus.upd_req   = 1'b0;
    bus.incr_in   = '0;
    bus.offset_in = '0;

    // cycles, en, sync, req, incr, off -> addr1, addr2, wrap, ack, busy
    vecs.push_back(mk(6,   1, 0, 0, 0,   0,    10,   10,   0, 0, 0));
    vecs.push_back(mk(1,   1, 0, 1, 32,  64,   11,   11,   0, 0, 1));
    vecs.push_back(mk(244, 1, 0, 0, 0,   0,    255,  255,  0, 0, 1));
    vecs.push_back(mk(1,   1, 0, 0, 0,   0,    0,    64,   1, 1, 0));
    vecs.push_back(mk(1,   1, 0, 0, 0,   0,    2,    66,   0, 0, 0));
    vecs.push_back(mk(1,   1, 0, 0, 0,   0,    4,    68,   0, 0, 0));
    vecs.push_back(mk(1,   0, 0, 1, 16,  200,  4,    68,   0, 0, 1));
    vecs.push_back(mk(1,   0, 0, 1, 48,  5,    4,    204,  0, 1, 0));
    vecs.push_back(mk(1,   0, 0, 0, 0,   0,    4,    204,  0, 0, 0));
    vecs.push_back(mk(1,   1, 0, 0, 0,   0,    5,    205,  0, 0, 0));
    vecs.push_back(mk(94,  1, 0, 0, 0,   0,    99,   43,   0, 0, 0));
    vecs.push_back(mk(1,   1, 0, 1, 48,  30,   100,  44,   0, 0, 1));
    vecs.push_back(mk(1,   1, 1, 0, 0,   0,    0,    30,   0, 1, 0));
    vecs.push_back(mk(1,   1, 0, 0, 0,   0,    3,    33,   0, 0, 0));
    vecs.push_back(mk(1,   0, 1, 1, 16,  0,    0,    0,    0, 1, 0));
    vecs.push_back(mk(77,  1, 0, 0, 0,   0,    77,   77,   0, 0, 0));
    vecs.push_back(mk(1,   0, 0, 1, 32,  10,   77,   77,   0, 0, 1));
    // Entries below run after the mid-pending reset.
    vecs.push_back(mk(1,   1, 0, 0, 0,   0,    1,    1,    0, 0, 0));
    vecs.push_back(mk(1,   1, 0, 0, 0,   0,    2,    2,    0, 0, 0));
    vecs.push_back(mk(1,   1, 0, 0, 0,   0,    3,    3,    0, 0, 0));
    vecs.push_back(mk(1,   0, 0, 1, 16,  240,  3,    3,    0, 0, 1));
    vecs.push_back(mk(1,   0, 0, 0, 0,   0,    3,    243,  0, 1, 0));
    vecs.push_back(mk(29,  1, 0, 0, 0,   0,    32,   16,   0, 0, 0));
    vecs.push_back(mk(1,   0, 0, 1, 0,   0,    32,   16,   0, 0, 1));
    vecs.push_back(mk(1,   0, 0, 0, 0,   0,    32,   32,   0, 1, 0));
    vecs.push_back(mk(3,   1, 0, 0, 0,   0,    32,   32,   0, 0, 0));
    vecs.push_back(mk(1,   1, 0, 1, 16,  1,    32,   32,   0, 0, 1));
    vecs.push_back(mk(5,   1, 0, 0, 0,   0,    32,   32,   0, 0, 1));
    vecs.push_back(mk(1,   0, 0, 0, 0,   0,    32,   33,   0, 1, 0));
    vecs.push_back(mk(1,   1, 0, 0, 0,   0,    33,   34,   0, 0, 0));

    #1;
    checkAll("reset", 0, 0, 0, 0, 0);
    step();
    step();
    rst = 1'b1;

    // Free run: one address per cycle, wrap in the cycle addr1 returns to 0.
    bus.en = 1'b1;
    for (int k = 1; k <= 260; k++) begin
      step();
      checkOutput($sformatf("run%0d addr1", k), int'(bus.addr1), k % 256);
      checkOutput($sformatf("run%0d addr2", k), int'(bus.addr2), k % 256);
      checkOutput($sformatf("run%0d wrap", k), int'(bus.wrap), (k % 256 == 0) ? 1 : 0);
    end

    for (int i = 0; i < 17; i++) applyStimulus(vecs[i], i);

    // Asynchronous reset while an update is pending.
    #2;
    rst = 1'b0;
    #1;
    checkAll("async_rst", 0, 0, 0, 0, 0);
    step();
    checkAll("rst_held", 0, 0, 0, 0, 0);
    rst = 1'b1;

    for (int i = 17; i < vecs.size(); i++) applyStimulus(vecs[i], i);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/sine_addr_gen.md
# sine_addr_gen

Dual-phase address generator that drives the two address ports of the dual-port sine ROM. A fractional phase accumulator sets the output frequency. A programmable offset gives the second channel's phase shift. New frequency and offset settings arrive over a req/ack handshake and are applied only at a wrap boundary, so the waveform never glitches mid-cycle. Both addresses are registered and change on the same edge; ROM data follows one cycle later.

## Interface
- ADDRESS_WIDTH, 8, ROM address width; width of addr1/addr2/offset_in.
- FRAC_WIDTH, 4, fractional accumulator bits below the address.
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-low reset (clears all state immediately while low).
- en  in  1  advance accumulator this cycle.
- sync  in  1  synchronous phase clear.
- upd_req  in  1  request to load incr_in/offset_in.
- incr_in  in  ADDRESS_WIDTH+FRAC_WIDTH  new phase increment.
- offset_in  in  ADDRESS_WIDTH  new addr2 phase offset.
- upd_busy  out  1  an update is pending; further requests are ignored.
- upd_ack  out  1  one-cycle pulse on the edge the pending update takes effect.
- addr1  out  ADDRESS_WIDTH  channel-1 ROM address.
- addr2  out  ADDRESS_WIDTH  channel-2 ROM address.
- wrap  out  1  one-cycle pulse when the accumulator overflows.

## Operation
- Registers:
  - acc (AW+FW bits)
  - incr_act, reset value 2^FRAC_WIDTH (one address per cycle)
  - off_act, reset value 0
  - shadow incr_sh/off_sh
  - state {IDLE, PENDING}
- addr1 = acc[AW+FW-1:FW].
- addr2 is registered, updated on every edge that changes acc or off_act, to the new addr1 + the new off_act, mod 2^AW (carry discarded).
- Accumulate (en=1, sync=0):
  - acc <= (acc + incr_act) mod 2^(AW+FW).
  - wrap <= carry-out of that add. Otherwise wrap <= 0.
- en=0, sync=0: acc holds, wrap=0.
- Handshake, IDLE:
  - upd_req=1 → capture incr_in/offset_in into the shadow registers and go to PENDING.
  - upd_busy is high from the next cycle.
- PENDING, application rules:
  - en=1 and the add carries: incr_act/off_act <= shadow, upd_ack <= 1, state → IDLE. The increment used on that edge is the old incr_act; addr2 on that edge uses the new offset.
  - en=0: apply on the next edge (idle generator updates at once).
  - Otherwise stay in PENDING. upd_req is ignored while in PENDING.
- sync=1 (priority over en):
  - acc <= 0, wrap <= 0.
  - If PENDING, or if a request is accepted on this same edge (IDLE and upd_req=1), that update is applied immediately: incr_act/off_act loaded, upd_ack <= 1, state → IDLE.
- incr_act = 0 is legal: acc freezes, and a pending update then waits until en=0 or sync.
- Reset (rst low), any time including mid-PENDING:
  - acc=0, addr1=0, addr2=0, wrap=0, upd_ack=0, upd_busy=0, state=IDLE
  - incr_act=2^FW, off_act=0
  - shadow contents discarded.

## Timing
- Latency: en edge → addr1/addr2 update on that edge. ROM dout follows one clock after the address.
- upd_req sampled at edge N → upd_busy=1 after edge N, until the edge that asserts upd_ack.
- upd_ack and upd_busy never both high in the same cycle: busy drops on the edge that raises ack.
- wrap and upd_ack may coincide (wrap-boundary apply).
- A new request may be issued in the cycle upd_ack is high. It is accepted at the next edge.
- Reset release is synchronous to clk from the design's viewpoint. The first state change happens on the first edge with rst=1.

## Test plan
- Reset, then en=1 for 260 cycles:
  - addr1 = 0,1,2,…,255,0,1,…
  - addr2 == addr1
  - wrap high only in the cycle after addr1 goes 255→0, then again 256 cycles later.
- At addr1=10, pulse upd_req with incr_in=32, offset_in=64:
  - upd_busy=1 from the next cycle.
  - addr1 keeps stepping by 1 until 255→0. On that edge: upd_ack=1, wrap=1, addr2=64.
  - Following cycles: addr1=2,4,…; addr2=66,68,…
- en=0, upd_req with incr_in=16, offset_in=200:
  - The next edge gives upd_ack=1, addr2=(addr1+200) mod 256, acc unchanged.
  - Then a second upd_req is issued while busy: ignored, no extra ack.
- PENDING request, then sync=1 at addr1=100:
  - Next edge: addr1=0, addr2=new offset, upd_ack=1, upd_busy=0, wrap=0.
- Assert rst low mid-PENDING at addr1=77:
  - Immediately: addr1=0, addr2=0, upd_busy=0.
  - After release with en=1: addr1 steps 0,1,2 with offset 0, and no upd_ack ever fires.
- offset_in=0xF0 with addr1=0x20: addr2=0x10 (modulo wrap, carry dropped).
